jtag_host_driver: RTL and testbench

JTAG_HOST_DRIVER -- requirements
Module: jtag_host_driver

---
 rtl/jtag_host_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_driver.sv
// jtag_host_driver
//   Command-driven JTAG host. A command (RESET, SHIFT_IR, SHIFT_DR, IDLE) is
//   accepted on a valid/ready handshake. It is played out as a series of TCK
//   slots, each CLK_DIV clk cycles low followed by CLK_DIV clk cycles high.
//   TDO is captured at the end of every shift slot, and the captured bits are
//   returned on a valid/ready response channel.
//
// Optional feature:
//   `define JTAG_HOST_TRST_EN  -- RESET first pulses trst_n low for one slot
//                                time, with tck held at 0.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op[1:0]                    00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
//   cmd_len[5:0]                   shift bit count (clamped to 1..32), or idle slots
//   cmd_data[31:0]                 shift data, LSB first
//   rsp_valid/rsp_ready            response handshake
//   rsp_data[31:0]                 captured TDO bits, LSB first
//   tck, tms, tdi, trst_n, tdo     JTAG pins
//   busy                           high whenever not idle
module jtag_host_driver #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  output logic        trst_n,
  input  logic        tdo,
  output logic        busy
);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef JTAG_HOST_TRST_EN
    S_TRST,
`endif
    S_PRE,
    S_SHIFT,
    S_POST,
    S_RESP
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  idx, idx_nx;
  logic [7:0]  div_cnt, div_nx;
  logic        phase, phase_nx;
  logic        start_slot, accept, slot_end, slot_active;
  logic        tms_nx, tdi_nx;
  logic [1:0]  op_q, op_sel;
  logic [5:0]  len_q, len_in, pre_last;
  logic [31:0] data_q, cap;

  // Shift ops keep the clamped bit count; IDLE keeps the raw slot count.
  always_comb begin
    if (cmd_len == 6'd0)       len_in = 6'd1;
    else if (cmd_len > 6'd32)  len_in = 6'd32;
    else                       len_in = cmd_len;
    if (cmd_op == OP_IDLE)     len_in = cmd_len;
  end

  // The first slot's TMS is computed before op_q has been loaded.
  assign op_sel   = (state == S_IDLE) ? cmd_op : op_q;
  assign slot_end = phase && (div_cnt == DIV_LAST);

  always_comb begin
    case (op_q)
      OP_RESET: pre_last = 6'd5;
      OP_IR:    pre_last = 6'd3;
      OP_DR:    pre_last = 6'd2;
      default:  pre_last = len_q - 6'd1;
    endcase
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    start_slot = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        accept = 1'b1;
        idx_nx = 6'd0;
        if (cmd_op == OP_RESET) begin
`ifdef JTAG_HOST_TRST_EN
          state_nx = S_TRST;
`else
          state_nx = S_PRE;
`endif
          start_slot = 1'b1;
        end else if (cmd_op == OP_IDLE && cmd_len == 6'd0) begin
          state_nx = S_RESP;
        end else begin
          state_nx   = S_PRE;
          start_slot = 1'b1;
        end
      end
`ifdef JTAG_HOST_TRST_EN
      S_TRST: if (slot_end) begin
        state_nx   = S_PRE;
        idx_nx     = 6'd0;
        start_slot = 1'b1;
      end
`endif
      S_PRE: if (slot_end) begin
        if (idx == pre_last) begin
          idx_nx = 6'd0;
          if (op_q == OP_IR || op_q == OP_DR) begin
            state_nx   = S_SHIFT;
            start_slot = 1'b1;
          end else begin
            state_nx = S_RESP;
          end
        end else begin
          idx_nx     = idx + 6'd1;
          start_slot = 1'b1;
        end
      end
      S_SHIFT: if (slot_end) begin
        start_slot = 1'b1;
        if (idx == len_q - 6'd1) begin
          state_nx = S_POST;
          idx_nx   = 6'd0;
        end else begin
          idx_nx = idx + 6'd1;
        end
      end
      S_POST: if (slot_end) begin
        if (idx == 6'd1) begin
          state_nx = S_RESP;
        end else begin
          idx_nx     = idx + 6'd1;
          start_slot = 1'b1;
        end
      end
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Pin values for the slot about to start; tms holds outside the slot states.
  always_comb begin
    tms_nx = tms;
    tdi_nx = 1'b0;
    case (state_nx)
      S_PRE: begin
        case (op_sel)
          OP_RESET: tms_nx = (idx_nx < 6'd5);
          OP_IR:    tms_nx = (idx_nx < 6'd2);
          OP_DR:    tms_nx = (idx_nx == 6'd0);
          default:  tms_nx = 1'b0;
        endcase
      end
      S_SHIFT: begin
        tms_nx = (idx_nx == len_q - 6'd1);
        tdi_nx = data_q[idx_nx[4:0]];
      end
      S_POST:  tms_nx = (idx_nx == 6'd0);
      default: ;
    endcase
  end

  // Slot timer: CLK_DIV cycles per phase, restarted at every slot start.
  always_comb begin
    div_nx   = div_cnt + 8'd1;
    phase_nx = phase;
    if (start_slot) begin
      div_nx   = 8'd0;
      phase_nx = 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_nx   = 8'd0;
      phase_nx = ~phase;
    end
    slot_active = (state_nx == S_PRE) || (state_nx == S_SHIFT) || (state_nx == S_POST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 6'd0;
      div_cnt <= 8'd0;
      phase   <= 1'b0;
      tck     <= 1'b0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
      cap     <= 32'd0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      div_cnt <= div_nx;
      phase   <= phase_nx;
      tck     <= phase_nx && slot_active;
      if (start_slot) begin
        tms <= tms_nx;
        tdi <= tdi_nx;
      end
      if (accept)
        cap <= 32'd0;
      else if (state == S_SHIFT && slot_end)
        cap[idx[4:0]] <= tdo;
    end
  end

  // Command payload is captured once at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      len_q  <= len_in;
      data_q <= cmd_data;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = cap;

`ifdef JTAG_HOST_TRST_EN
  assign trst_n = (state != S_TRST);
`else
  assign trst_n = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver
//   Bench for jtag_host_driver with CLK_DIV=2. A slot-list model built from
//   the command rules predicts every pin on every cycle. Directed commands
//   pin latency, pulse counts and captured data to literal values, and a
//   randomized command loop follows.
module tb_jtag_host_driver;

  localparam int D = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_RESP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, trst_n, busy;
  logic        tdo = 1'b0;

  jtag_host_driver #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n), .tdo(tdo), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: list of slots per command ----------
  int          n_sl;
  bit          s_tms [80];
  bit          s_tdi [80];
  bit          s_trst[80];
  int          s_sh  [80];
  bit          tdo_pat[80];
  logic [31:0] exp_rsp;
  bit          idle_tms = 1'b1;
  bit          tdo_prev = 1'b0;
  int          m_state = M_IDLE;
  int          ncyc = 0, t_acc = 0, acc_cnt = 0, done_cnt = 0;
  int          k, s, pos;
  int          pulses = 0;

  always @(posedge tck) pulses++;

  task automatic add_slot(input bit t, input bit d, input bit tr, input int sh);
    s_tms[n_sl] = t; s_tdi[n_sl] = d; s_trst[n_sl] = tr; s_sh[n_sl] = sh;
    n_sl++;
  endtask

  task automatic add_shift(input int L, input logic [31:0] data);
    for (int i = 0; i < L; i++) add_slot(i == L - 1, data[i], 1'b0, i);
  endtask

  task automatic build(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int L;
    n_sl = 0;
    L = (len == 0) ? 1 : (len > 32) ? 32 : int'(len);
    case (op)
      2'b00: begin
`ifdef JTAG_HOST_TRST_EN
        add_slot(idle_tms, 1'b0, 1'b1, -1);
`endif
        for (int i = 0; i < 6; i++) add_slot(i < 5, 1'b0, 1'b0, -1);
      end
      2'b01: begin
        add_slot(1, 0, 0, -1); add_slot(1, 0, 0, -1);
        add_slot(0, 0, 0, -1); add_slot(0, 0, 0, -1);
        add_shift(L, data);
        add_slot(1, 0, 0, -1); add_slot(0, 0, 0, -1);
      end
      2'b10: begin
        add_slot(1, 0, 0, -1); add_slot(0, 0, 0, -1); add_slot(0, 0, 0, -1);
        add_shift(L, data);
        add_slot(1, 0, 0, -1); add_slot(0, 0, 0, -1);
      end
      default: for (int i = 0; i < int'(len); i++) add_slot(0, 0, 0, -1);
    endcase
    exp_rsp = 32'd0;
    for (int i = 0; i < n_sl; i++) begin
      tdo_pat[i] = tdo_prev ? ((i == 0) ? 1'b0 : s_tdi[i-1]) : 1'($urandom_range(0, 1));
      if (s_sh[i] >= 0) exp_rsp[s_sh[i]] = tdo_pat[i];
    end
  endtask

  // ---------------- compare process: every negedge ----------------
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      m_state  = M_IDLE;
      idle_tms = 1'b1;
      tdo      = 1'b0;
      chk1("rst_tck", tck, 1'b0);
      chk1("rst_tms", tms, 1'b1);
      chk1("rst_tdi", tdi, 1'b0);
      chk1("rst_trst_n", trst_n, 1'b1);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_cmd_ready", cmd_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_rsp_data", rsp_data, 32'd0);
    end else begin
      case (m_state)
        M_IDLE: begin
          tdo = 1'b0;
          chk1("idle_cmd_ready", cmd_ready, 1'b1);
          chk1("idle_busy", busy, 1'b0);
          chk1("idle_rsp_valid", rsp_valid, 1'b0);
          chk1("idle_tck", tck, 1'b0);
          chk1("idle_tms", tms, idle_tms);
          chk1("idle_tdi", tdi, 1'b0);
          chk1("idle_trst_n", trst_n, 1'b1);
          if (cmd_valid) begin
            build(cmd_op, cmd_len, cmd_data);
            t_acc = ncyc;
            k = 0;
            acc_cnt++;
            m_state = (n_sl == 0) ? M_RESP : M_RUN;
          end
        end
        M_RUN: begin
          k++;
          s   = (k - 1) / (2 * D);
          pos = (k - 1) % (2 * D);
          tdo = tdo_pat[s];
          chk1("run_tck", tck, (pos >= D) && !s_trst[s]);
          chk1("run_tms", tms, s_tms[s]);
          chk1("run_tdi", tdi, s_tdi[s]);
          chk1("run_trst_n", trst_n, !s_trst[s]);
          chk1("run_busy", busy, 1'b1);
          chk1("run_cmd_ready", cmd_ready, 1'b0);
          chk1("run_rsp_valid", rsp_valid, 1'b0);
          if (k == n_sl * 2 * D) begin
            idle_tms = s_tms[n_sl-1];
            m_state  = M_RESP;
          end
        end
        default: begin
          tdo = 1'b0;
          chk1("resp_valid", rsp_valid, 1'b1);
          chk32("resp_data", rsp_data, exp_rsp);
          chk1("resp_busy", busy, 1'b1);
          chk1("resp_cmd_ready", cmd_ready, 1'b0);
          chk1("resp_tck", tck, 1'b0);
          chk1("resp_tms", tms, idle_tms);
          chk1("resp_tdi", tdi, 1'b0);
          chk1("resp_trst_n", trst_n, 1'b1);
          if (rsp_ready) begin
            m_state = M_IDLE;
            done_cnt++;
          end
        end
      endcase
    end
  end

  // ---------------- driver ----------------
  int p0;

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int a0, g;
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    p0 = pulses;
    a0 = acc_cnt;
    g  = 0;
    while (acc_cnt == a0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    chk1("accept_in_time", acc_cnt != a0, 1'b1);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 6'($urandom);
    cmd_data  = $urandom;
  endtask

  task automatic recv(input int hold, input bit nxt, input logic [1:0] nop,
                      input logic [5:0] nlen, input logic [31:0] ndata,
                      output logic [31:0] got, output int lat);
    int g, d0;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while (rsp_valid !== 1'b1 && g < 3000);
    chk1("rsp_in_time", rsp_valid, 1'b1);
    lat = ncyc - t_acc;
    got = rsp_data;
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    if (nxt) begin
      cmd_op = nop; cmd_len = nlen; cmd_data = ndata; cmd_valid = 1'b1;
    end
    d0 = done_cnt;
    g  = 0;
    while (done_cnt == d0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    chk1("handshake_in_time", done_cnt != d0, 1'b1);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] nd;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 6'd0;
    cmd_data = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // RESET
    send(2'b00, 6'd0, 32'hFFFF_FFFF);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
`ifdef JTAG_HOST_TRST_EN
    chk32("reset_latency", 32'(lat), 32'd29);
`else
    chk32("reset_latency", 32'(lat), 32'd25);
`endif
    chk32("reset_pulses", 32'(pulses - p0), 32'd6);
    chk32("reset_rsp", got, 32'd0);

    // SHIFT_DR len 8, TDO echoes the previous slot's TDI
    tdo_prev = 1'b1;
    send(2'b10, 6'd8, 32'h0000_00A5);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("dr8_latency", 32'(lat), 32'd53);
    chk32("dr8_pulses", 32'(pulses - p0), 32'd13);
    chk32("dr8_rsp", got, 32'h0000_004A);
    tdo_prev = 1'b0;

    // SHIFT_IR clamp boundaries
    send(2'b01, 6'd0, 32'hFFFF_FFFF);
    recv(1, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("ir0_pulses", 32'(pulses - p0), 32'd7);
    chk32("ir0_rsp_hi", got >> 1, 32'd0);
    send(2'b01, 6'd40, $urandom);
    recv(2, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("ir40_pulses", 32'(pulses - p0), 32'd38);
    send(2'b01, 6'd32, $urandom);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("ir32_pulses", 32'(pulses - p0), 32'd38);

    // IDLE op
    send(2'b11, 6'd0, $urandom);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("idle0_latency", 32'(lat), 32'd1);
    chk32("idle0_pulses", 32'(pulses - p0), 32'd0);
    send(2'b11, 6'd3, $urandom);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("idle3_latency", 32'(lat), 32'd13);
    chk32("idle3_pulses", 32'(pulses - p0), 32'd3);

    // Held response, with the next command offered during the handshake
    nd = $urandom;
    send(2'b10, 6'd5, $urandom);
    recv(10, 1'b1, 2'b01, 6'd4, nd, got, lat);
    send(2'b01, 6'd4, nd);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    chk32("ir4_latency", 32'(lat), 32'd41);

    // Reset in the middle of a shift, then a normal RESET
    send(2'b10, 6'd20, $urandom);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_tck", tck, 1'b0);
    chk1("async_rst_tms", tms, 1'b1);
    chk1("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("async_rst_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(2'b00, 6'd0, $urandom);
    recv(0, 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
`ifdef JTAG_HOST_TRST_EN
    chk32("reset2_latency", 32'(lat), 32'd29);
`else
    chk32("reset2_latency", 32'(lat), 32'd25);
`endif

    // Randomized commands
    for (int it = 0; it < 40; it++) begin
      op  = 2'($urandom_range(0, 3));
      len = 6'($urandom_range(0, 63));
      if (op != 2'b11 && $urandom_range(0, 1) == 1) len = 6'($urandom_range(0, 3) + 30);
      tdo_prev = 1'($urandom_range(0, 1));
      send(op, len, $urandom);
      recv($urandom_range(0, 3), 1'b0, 2'b00, 6'd0, 32'd0, got, lat);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
